// File: rtl/cheri_trvk_stage_mc.sv
//------------------------------------------------------------------------------
// cheri_trvk_stage_mc
//   Multi-channel temporal-revocation checker. Requesters present a loaded
//   capability; the stage derives its base, looks up the revocation bit in the
//   tag-shadow map (TSMAP) and returns a per-channel clear-tag decision.
//   A one-word TSMAP cache avoids memory reads for repeated lookups in the
//   same map word.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_*                    per-channel request (valid/ready, err, data,
//                            capability metadata, opaque tag)
//   rsp_valid_o/clrtag/tag   one-cycle response on the granted channel bit
//   tsmap_*                  variable-latency req/gnt/rvalid read port, plus
//                            an invalidate strobe from the revoker
//   busy_o                   FSM not idle
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cheri_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] exp;
    logic [8:0] base;
    logic [1:0] base_cor;   // signed correction applied above the mantissa
    logic [4:0] cperms;
  } reg_cap_t;

  // Rebuild the 32-bit base from the compressed mantissa: the bits above
  // exp+9 come from the address (corrected by base_cor), the mantissa sits
  // at bit position exp.
  function automatic logic [31:0] get_base32(input logic [8:0] base,
                                             input logic [1:0] base_cor,
                                             input logic [4:0] exp,
                                             input logic [31:0] addr);
    logic [5:0]  sh;
    logic [31:0] hi;
    logic [31:0] cor;
    sh  = {1'b0, exp} + 6'd9;
    hi  = addr >> sh;
    cor = {{30{base_cor[1]}}, base_cor};
    return ((hi + cor) << sh) | ({23'b0, base} << exp);
  endfunction
endpackage

module cheri_trvk_stage_mc
  import cheri_pkg::*;
#(
  parameter logic [31:0] HeapBase     = 32'h8000_0000,
  parameter int unsigned TSMapSize    = 1024,
  parameter int unsigned GranuleShift = 3,
  parameter int unsigned NumChan      = 2,
  parameter int unsigned TagW         = 5,
  localparam int unsigned AddrW       = $clog2(TSMapSize)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumChan-1:0]        req_valid_i,
  output logic [NumChan-1:0]        req_ready_o,
  input  logic [NumChan-1:0]        req_err_i,
  input  logic [NumChan*32-1:0]     req_data_i,
  input  reg_cap_t [NumChan-1:0]    req_cap_i,
  input  logic [NumChan*TagW-1:0]   req_tag_i,
  output logic [NumChan-1:0]        rsp_valid_o,
  output logic                      rsp_clrtag_o,
  output logic [TagW-1:0]           rsp_tag_o,
  output logic                      tsmap_req_o,
  input  logic                      tsmap_gnt_i,
  output logic [AddrW-1:0]          tsmap_addr_o,
  input  logic                      tsmap_rvalid_i,
  input  logic [31:0]               tsmap_rdata_i,
  input  logic                      tsmap_inval_i,
  output logic                      busy_o
);

  localparam int unsigned ChW = (NumChan > 1) ? $clog2(NumChan) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  state_e r_state, w_state_n;

  logic [ChW-1:0]  r_ptr;
  logic [ChW-1:0]  r_chan;
  reg_cap_t        r_cap;
  logic [31:0]     r_data;
  logic [TagW-1:0] r_tag;
  logic            r_good;
  logic            r_clrtag;
  logic            r_inval_seen;
  logic            r_c_valid;
  logic [AddrW-1:0] r_c_addr;
  logic [31:0]     r_c_data;

  logic [NumChan-1:0][31:0]   w_data_arr;
  logic [NumChan-1:0][TagW-1:0] w_tag_arr;
  logic [ChW:0]        w_k;
  logic [ChW-1:0]      w_arb_idx;
  logic                w_arb_found;
  logic [NumChan-1:0]  w_gnt_vec;
  logic [31:0]         w_base32, w_off, w_gidx, w_widx;
  logic [4:0]          w_bit;
  logic                w_in_range, w_sealed, w_hit;
  logic                w_accept, w_set_clr, w_clr_val, w_fill;

  assign w_data_arr = req_data_i;
  assign w_tag_arr  = req_tag_i;

  // Round-robin: scan channels starting at the pointer, first valid wins.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_k         = '0;
    for (int i = 0; i < NumChan; i++) begin
      w_k = {1'b0, r_ptr} + (ChW+1)'(i);
      if (w_k >= (ChW+1)'(NumChan)) w_k = w_k - (ChW+1)'(NumChan);
      if (!w_arb_found && req_valid_i[w_k[ChW-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_k[ChW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_vec   = '0;
    rsp_valid_o = '0;
    for (int i = 0; i < NumChan; i++) begin
      w_gnt_vec[i]   = (w_arb_idx == ChW'(i));
      rsp_valid_o[i] = (r_state == ST_RESP) && (r_chan == ChW'(i));
    end
  end

  // Lookup index derived from the captured request; stable from CALC to WAIT.
  // A base below HeapBase wraps in w_off and is caught by the >= term.
  assign w_base32   = get_base32(r_cap.base, r_cap.base_cor, r_cap.exp, r_data);
  assign w_off      = w_base32 - HeapBase;
  assign w_gidx     = w_off >> GranuleShift;
  assign w_widx     = w_gidx >> 5;
  assign w_bit      = w_gidx[4:0];
  assign w_in_range = (w_base32 >= HeapBase) && (w_widx < TSMapSize);
  assign w_sealed   = (r_cap.cperms[4:3] == 2'b00) && (|r_cap.cperms[2:0]);
  assign w_hit      = r_c_valid && (r_c_addr == w_widx[AddrW-1:0]) && !tsmap_inval_i;

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_set_clr = 1'b0;
    w_clr_val = 1'b0;
    w_fill    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_accept  = 1'b1;
          w_state_n = ST_CALC;
        end
      end
      ST_CALC: begin
        if (!r_good || !w_in_range || w_sealed) begin
          w_set_clr = 1'b1;
          w_state_n = ST_RESP;
        end else if (w_hit) begin
          w_set_clr = 1'b1;
          w_clr_val = r_c_data[w_bit];
          w_state_n = ST_RESP;
        end else begin
          w_state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tsmap_gnt_i) w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (tsmap_rvalid_i) begin
          w_set_clr = 1'b1;
          w_clr_val = tsmap_rdata_i[w_bit];
          // Data raced with a revoker write: use it once, never cache it.
          w_fill    = !(r_inval_seen || tsmap_inval_i);
          w_state_n = ST_RESP;
        end
      end
      ST_RESP: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign req_ready_o  = (r_state == ST_IDLE && w_arb_found) ? w_gnt_vec : '0;
  assign tsmap_req_o  = (r_state == ST_REQ);
  assign tsmap_addr_o = (r_state == ST_REQ) ? w_widx[AddrW-1:0] : '0;
  assign rsp_clrtag_o = (r_state == ST_RESP) ? r_clrtag : 1'b0;
  assign rsp_tag_o    = (r_state == ST_RESP) ? r_tag : '0;
  assign busy_o       = (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr        <= '0;
      r_chan       <= '0;
      r_cap        <= '0;
      r_data       <= '0;
      r_tag        <= '0;
      r_good       <= 1'b0;
      r_clrtag     <= 1'b0;
      r_inval_seen <= 1'b0;
      r_c_valid    <= 1'b0;
      r_c_addr     <= '0;
      r_c_data     <= '0;
    end else begin
      if (w_accept) begin
        r_ptr  <= (w_arb_idx == ChW'(NumChan-1)) ? '0 : w_arb_idx + 1'b1;
        r_chan <= w_arb_idx;
        r_cap  <= req_cap_i[w_arb_idx];
        r_data <= w_data_arr[w_arb_idx];
        r_tag  <= w_tag_arr[w_arb_idx];
        r_good <= ~req_err_i[w_arb_idx] & req_cap_i[w_arb_idx].valid;
      end
      if (w_set_clr) r_clrtag <= w_clr_val;
      // Invalidate tracking window opens when the lookup leaves CALC.
      if (r_state == ST_CALC)  r_inval_seen <= 1'b0;
      else if (tsmap_inval_i)  r_inval_seen <= 1'b1;
      if (w_fill) begin
        r_c_valid <= 1'b1;
        r_c_addr  <= w_widx[AddrW-1:0];
        r_c_data  <= tsmap_rdata_i;
      end else if (tsmap_inval_i) begin
        r_c_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cheri_trvk_stage_mc.sv
//------------------------------------------------------------------------------
// tb_cheri_trvk_stage_mc
//   Directed bench: default 2-channel build (dut0) with a TSMAP responder
//   whose grant and read-valid can be stalled, plus a 4-channel
//   GranuleShift=4 build (dut1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cheri_trvk_stage_mc;
  import cheri_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic reg_cap_t mk_cap(input logic [31:0] a, input logic [4:0] p);
    reg_cap_t c;
    c.valid    = 1'b1;
    c.exp      = 5'd0;
    c.base     = a[8:0];
    c.base_cor = 2'b00;
    c.cperms   = p;
    return c;
  endfunction

  // ---------------- dut0: default parameters ----------------
  logic [1:0]        v0 = '0, e0 = '0, rdy0, rsv0;
  logic [63:0]       d0 = '0;
  reg_cap_t [1:0]    c0 = '0;
  logic [9:0]        t0 = '0;
  logic              clr0, treq0, gnt0, trv0, inv0 = 1'b0, busy0;
  logic [4:0]        rtag0;
  logic [9:0]        taddr0;
  logic [31:0]       trd0;

  logic              gnt_en = 1'b1, auto_rv = 1'b1, man_rv = 1'b0;
  logic [31:0]       man_rd = '0;
  logic              rv_q = 1'b0;
  logic [31:0]       rd_q = '0;
  int                hs0 = 0;
  logic [9:0]        la0 = '0;
  logic [31:0]       tsmem [0:1023];

  assign gnt0 = treq0 & gnt_en;
  assign trv0 = auto_rv ? rv_q : man_rv;
  assign trd0 = auto_rv ? rd_q : man_rd;

  always @(posedge clk) begin
    if (treq0 && gnt0) begin
      hs0  <= hs0 + 1;
      la0  <= taddr0;
      rv_q <= 1'b1;
      rd_q <= tsmem[taddr0];
    end else begin
      rv_q <= 1'b0;
    end
  end

  cheri_trvk_stage_mc dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v0), .req_ready_o(rdy0), .req_err_i(e0),
    .req_data_i(d0), .req_cap_i(c0), .req_tag_i(t0),
    .rsp_valid_o(rsv0), .rsp_clrtag_o(clr0), .rsp_tag_o(rtag0),
    .tsmap_req_o(treq0), .tsmap_gnt_i(gnt0), .tsmap_addr_o(taddr0),
    .tsmap_rvalid_i(trv0), .tsmap_rdata_i(trd0), .tsmap_inval_i(inv0),
    .busy_o(busy0)
  );

  // ---------------- dut1: 4 channels, 16-byte granules ----------------
  logic [3:0]        v1 = '0, e1 = '0, rdy1, rsv1;
  logic [127:0]      d1 = '0;
  reg_cap_t [3:0]    c1 = '0;
  logic [19:0]       t1 = '0;
  logic              clr1, treq1, trv1, busy1;
  logic [4:0]        rtag1;
  logic [9:0]        taddr1;
  logic [31:0]       trd1;
  logic              rv1_q = 1'b0;
  logic [31:0]       rd1_q = '0;
  logic [9:0]        la1 = '0;

  assign trv1 = rv1_q;
  assign trd1 = rd1_q;
  always @(posedge clk) begin
    rv1_q <= treq1;
    if (treq1) begin
      la1   <= taddr1;
      rd1_q <= (taddr1 == 10'd1) ? 32'h0000_0002 : 32'h0;
    end
  end

  cheri_trvk_stage_mc #(.NumChan(4), .GranuleShift(4), .TagW(5)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_err_i(e1),
    .req_data_i(d1), .req_cap_i(c1), .req_tag_i(t1),
    .rsp_valid_o(rsv1), .rsp_clrtag_o(clr1), .rsp_tag_o(rtag1),
    .tsmap_req_o(treq1), .tsmap_gnt_i(treq1), .tsmap_addr_o(taddr1),
    .tsmap_rvalid_i(trv1), .tsmap_rdata_i(trd1), .tsmap_inval_i(1'b0),
    .busy_o(busy1)
  );

  // One request on dut0; reports latency from accept to response.
  task automatic send0(input int ch, input logic [31:0] data, input reg_cap_t cap,
                       input logic [4:0] tag, input logic err,
                       output int lat, output logic [1:0] rv,
                       output logic clr, output logic [4:0] rtag);
    int n;
    @(negedge clk);
    v0 = '0;
    v0[ch] = 1'b1;
    d0[ch*32 +: 32] = data;
    c0[ch] = cap;
    t0[ch*5 +: 5] = tag;
    e0[ch] = err;
    #1;
    n = 0;
    while (!rdy0[ch] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", {31'b0, rdy0[ch]}, 32'd1);
    @(negedge clk);
    v0 = '0; e0 = '0;
    #1;
    lat = 1;
    while (rsv0 == 2'b00 && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    rv = rsv0; clr = clr0; rtag = rtag0;
    if (rsv0 == 2'b00) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
  endtask

  initial begin
    int lat, hs_before, n;
    logic [1:0] rv;
    logic clr, seen;
    logic [4:0] rtag;

    for (int i = 0; i < 1024; i++) tsmem[i] = 32'h0;
    tsmem[1]    = 32'h0000_0002;
    tsmem[1023] = 32'h0000_0001;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy",   {31'b0, busy0}, 32'd0);
    chk("rst_rsp",    {30'b0, rsv0}, 32'd0);
    chk("rst_clrtag", {31'b0, clr0}, 32'd0);
    chk("rst_tag",    {27'b0, rtag0}, 32'd0);
    chk("rst_tsreq",  {31'b0, treq0}, 32'd0);

    // Miss: word 1 bit 1 set
    send0(0, 32'h8000_0108, mk_cap(32'h8000_0108, 5'b11111), 5'h13, 1'b0, lat, rv, clr, rtag);
    chk("miss_lat",   lat, 4);
    chk("miss_rv",    {30'b0, rv}, 32'd1);
    chk("miss_clr",   {31'b0, clr}, 32'd1);
    chk("miss_tag",   {27'b0, rtag}, 32'h13);
    chk("miss_addr",  {22'b0, la0}, 32'd1);
    chk("miss_hs",    hs0, 1);

    // Hit on the cached word, bit 0 clear
    send0(0, 32'h8000_0100, mk_cap(32'h8000_0100, 5'b11111), 5'h07, 1'b0, lat, rv, clr, rtag);
    chk("hit_lat",    lat, 2);
    chk("hit_clr",    {31'b0, clr}, 32'd0);
    chk("hit_hs",     hs0, 1);
    chk("hit_tag",    {27'b0, rtag}, 32'h07);

    // Invalidate, then the same lookup must go back to memory
    @(negedge clk); inv0 = 1'b1;
    @(negedge clk); inv0 = 1'b0;
    send0(0, 32'h8000_0100, mk_cap(32'h8000_0100, 5'b11111), 5'h08, 1'b0, lat, rv, clr, rtag);
    chk("inval_hs",   hs0, 2);
    chk("inval_lat",  lat, 4);
    chk("inval_clr",  {31'b0, clr}, 32'd0);

    // Below heap
    send0(0, 32'h7FFF_FFF8, mk_cap(32'h7FFF_FFF8, 5'b11111), 5'h01, 1'b0, lat, rv, clr, rtag);
    chk("low_lat", lat, 2);
    chk("low_clr", {31'b0, clr}, 32'd0);
    chk("low_hs",  hs0, 2);
    // First word past the map
    send0(0, 32'h8004_0000, mk_cap(32'h8004_0000, 5'b11111), 5'h02, 1'b0, lat, rv, clr, rtag);
    chk("high_lat", lat, 2);
    chk("high_clr", {31'b0, clr}, 32'd0);
    chk("high_hs",  hs0, 2);
    // Bus error on a cached, revoked granule
    send0(0, 32'h8000_0108, mk_cap(32'h8000_0108, 5'b11111), 5'h03, 1'b1, lat, rv, clr, rtag);
    chk("err_clr", {31'b0, clr}, 32'd0);
    chk("err_lat", lat, 2);
    // Sealed capability on the same granule
    send0(0, 32'h8000_0108, mk_cap(32'h8000_0108, 5'b00001), 5'h04, 1'b0, lat, rv, clr, rtag);
    chk("seal_clr", {31'b0, clr}, 32'd0);
    chk("seal_hs",  hs0, 2);
    // Last in-range word
    send0(0, 32'h8003_FF00, mk_cap(32'h8003_FF00, 5'b11111), 5'h05, 1'b0, lat, rv, clr, rtag);
    chk("last_addr", {22'b0, la0}, 32'd1023);
    chk("last_clr",  {31'b0, clr}, 32'd1);
    chk("last_hs",   hs0, 3);

    // Grant stall: address must hold while gnt is low
    gnt_en = 1'b0;
    @(negedge clk);
    v0 = 2'b01; e0 = '0;
    d0[31:0] = 32'h8000_0108;
    c0[0] = mk_cap(32'h8000_0108, 5'b11111);
    #1;
    @(negedge clk); v0 = '0; #1;
    n = 0;
    while (!treq0 && n < 10) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  {31'b0, treq0}, 32'd1);
      chk("stall_addr", {22'b0, taddr0}, 32'd1);
      @(negedge clk); #1;
    end
    auto_rv = 1'b0;
    gnt_en  = 1'b1;
    @(negedge clk); #1;
    chk("wait_busy", {31'b0, busy0}, 32'd1);
    chk("wait_req",  {31'b0, treq0}, 32'd0);
    do_reset();
    chk("rstw_busy", {31'b0, busy0}, 32'd0);
    man_rv = 1'b1; man_rd = 32'hFFFF_FFFF;
    @(negedge clk); man_rv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (rsv0 != 2'b00) seen = 1'b1;
      @(negedge clk);
    end
    auto_rv = 1'b1;
    chk("rstw_no_rsp", {31'b0, seen}, 32'd0);
    chk("rstw_busy2",  {31'b0, busy0}, 32'd0);
    // Word 1023 was cached before reset; a lookup must read memory again
    hs_before = hs0;
    send0(0, 32'h8003_FF00, mk_cap(32'h8003_FF00, 5'b11111), 5'h06, 1'b0, lat, rv, clr, rtag);
    chk("rstw_cache_inv", hs0 - hs_before, 1);

    // Round-robin from a freshly reset pointer
    do_reset();
    v0 = 2'b11;
    d0 = {32'h7FFF_FFF8, 32'h7FFF_FFF8};
    c0[0] = mk_cap(32'h7FFF_FFF8, 5'b11111);
    c0[1] = mk_cap(32'h7FFF_FFF8, 5'b11111);
    t0 = {5'h15, 5'h0A};
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (rdy0 == 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
      chk("arb_grant", {30'b0, rdy0}, (k % 2) ? 32'd2 : 32'd1);
      n = 0;
      @(negedge clk); #1;
      while (rsv0 == 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
      chk("arb_rsp", {30'b0, rsv0}, (k % 2) ? 32'd2 : 32'd1);
      chk("arb_tag", {27'b0, rtag0}, (k % 2) ? 32'h15 : 32'h0A);
    end
    v0 = '0;

    // dut1: channel 3, 16-byte granules: offset 0x210 -> word 1, bit 1
    @(negedge clk);
    v1[3] = 1'b1;
    d1[127:96] = 32'h8000_0210;
    c1[3] = mk_cap(32'h8000_0210, 5'b11111);
    t1[19:15] = 5'h1B;
    #1;
    n = 0;
    while (rdy1 == 4'b0 && n < 10) begin @(negedge clk); #1; n++; end
    chk("c3_grant", {28'b0, rdy1}, 32'h8);
    @(negedge clk); v1 = '0; #1;
    lat = 1;
    while (rsv1 == 4'b0 && lat < 40) begin @(negedge clk); #1; lat++; end
    chk("c3_rsp",  {28'b0, rsv1}, 32'h8);
    chk("c3_clr",  {31'b0, clr1}, 32'd1);
    chk("c3_tag",  {27'b0, rtag1}, 32'h1B);
    chk("c3_addr", {22'b0, la1}, 32'd1);
    chk("c3_lat",  lat, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/cheri_trvk_stage_mc.md
Name: cheri_trvk_stage_mc

Overview:
- Multi-channel temporal-revocation checker.
- Accepts loaded capabilities from NumChan requesters (ch0 = CPU load-cap, ch1 = TBRE, further channels for DMA/other engines).
- Derives each capability's base and looks up the revocation bit in the tag-shadow map (TSMAP) through a variable-latency req/gnt/rvalid port.
- Returns a per-channel clear-tag decision. A single-word TSMAP cache skips memory reads for consecutive lookups in the same map word.

Parameters:
- HeapBase, 32'h8000_0000, byte address of the first revocable heap granule.
- TSMapSize, 1024, number of 32-bit TSMAP words; legal range 2..65536.
- GranuleShift, 3, log2 of revocation granule size in bytes; legal range 3..6.
- NumChan, 2, number of requester channels; legal range 1..4.
- TagW, 5, width of the opaque per-request tag (e.g. RF address), returned unchanged.
- AddrW, $clog2(TSMapSize), TSMAP word address width; derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  NumChan  request valid per channel
- req_ready_o  out  NumChan  request accepted this cycle
- req_err_i  in  NumChan  load returned bus error
- req_data_i  in  NumChan*32  loaded address word, ch k at [32k+31:32k]
- req_cap_i  in  NumChan x cheri_pkg::reg_cap_t  loaded capability metadata
- req_tag_i  in  NumChan*TagW  request tag
- rsp_valid_o  out  NumChan  one-cycle response pulse
- rsp_clrtag_o  out  1  capability must have its tag cleared; qualified by any rsp_valid_o
- rsp_tag_o  out  TagW  tag of the responding request
- tsmap_req_o  out  1  TSMAP read request
- tsmap_gnt_i  in  1  request accepted
- tsmap_addr_o  out  AddrW  TSMAP word address
- tsmap_rvalid_i  in  1  read data valid
- tsmap_rdata_i  in  32  read data
- tsmap_inval_i  in  1  TSMAP written by revoker; drop cached word
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: FSM=IDLE; all outputs 0; cache valid=0; round-robin pointer=0. Reset mid-operation abandons the request with no response. A tsmap_rvalid_i arriving after reset while IDLE is ignored.
- FSM states: IDLE, CALC, REQ, WAIT, RESP. One request in flight at a time.
- Arbitration:
  - req_ready_o is asserted only in IDLE and goes to exactly one valid channel, chosen round-robin starting at the pointer.
  - On accept, the pointer advances to the granted channel + 1 (mod NumChan).
  - On accept, register cap, data, tag, channel index and good = ~req_err_i & cap.valid. Next state is CALC.
- CALC:
  - base32 = get_base32(base, base_cor, exp, data).
  - off = base32 - HeapBase.
  - gidx = off >> GranuleShift; widx = gidx >> 5; bit = gidx[4:0].
  - in_range = (base32 >= HeapBase) & (widx < TSMapSize). The comparison is strict; an index equal to TSMapSize is out of range.
  - sealed = (cperms[4:3]==2'b00) & |cperms[2:0].
  - If ~good | ~in_range | sealed, go to RESP with clrtag=0 and issue no TSMAP access.
  - Else, if cache valid & cache_addr==widx & ~tsmap_inval_i, go to RESP with clrtag = cache_data[bit].
  - Else go to REQ.
- REQ: tsmap_req_o=1 and tsmap_addr_o=widx[AddrW-1:0], both held stable until tsmap_gnt_i. On gnt, go to WAIT.
- WAIT:
  - On tsmap_rvalid_i, set clrtag = tsmap_rdata_i[bit] and go to RESP.
  - Also fill the cache (addr=widx, valid=1), unless tsmap_inval_i was seen at any point from REQ through this cycle; in that case the data is used but not cached.
- RESP: rsp_valid_o[chan]=1 for one cycle, with rsp_clrtag_o and rsp_tag_o driven. Next state is IDLE.
- tsmap_inval_i in any state clears cache valid the following cycle.
- Latency, accept to rsp_valid_o:
  - 2 cycles for bypass or cache hit.
  - 3 + gnt wait + rvalid wait for a miss; 4 cycles minimum with a same-cycle gnt and next-cycle rvalid.
- Throughput: next accept is possible in the cycle after RESP.
- Arithmetic: all 32-bit unsigned; a base below HeapBase wraps in subtraction and is rejected by the base32 >= HeapBase term.
- rsp_clrtag_o and rsp_tag_o are 0 whenever no rsp_valid_o is asserted.

Test Plan:
- Ch0 valid, cap.valid=1, data/base 0x8000_0108, defaults; TSMAP word 1 = 0x0000_0002, gnt same cycle, rvalid next cycle -> tsmap_addr_o=1; rsp_valid_o=2'b01, rsp_clrtag_o=1, returned tag matches, 4 cycles after accept.
- Repeat with base 0x8000_0100 (bit 0, word 1) -> no tsmap_req_o (cache hit), clrtag=0, 2-cycle latency. Then pulse tsmap_inval_i and repeat -> tsmap_req_o reasserted.
- Ch0 and ch1 valid every cycle for 4 requests -> grants alternate 0,1,0,1; each response appears on the matching rsp_valid_o bit with the matching tag.
- Base 0x7FFF_FFF8, then base HeapBase + TSMapSize*256 -> no TSMAP access, clrtag=0. Same with req_err_i=1, and with cperms[4:3]=00 and cperms[0]=1 -> clrtag=0.
- Hold tsmap_gnt_i low for 5 cycles -> tsmap_addr_o stable throughout. Assert rst_i while in WAIT, then deliver rvalid -> no rsp_valid_o, busy_o=0, cache invalid.
- TagW=5, NumChan=4, GranuleShift=4 build: base HeapBase+0x210 -> widx=1, bit=1; ch3 request returns on rsp_valid_o[3].
